// File: rtl/game_round_ctl.sv
// -----------------------------------------------------------------------------
// game_round_ctl
//
// Sequencer for one round of the tile-memory game. When the menu raises
// is_game_on the block latches board_size and lvl, fills a tile sequence from
// an 8-bit LFSR, shows the tiles one at a time to the board renderer, and then
// checks the player's clicks against the stored sequence. The round ends in a
// sticky win or lose state that the screen-overlay logic reads.
//
// Optional feature: define GAME_ROUND_TIMEOUT_EN to lose the round after
// INPUT_TIMEOUT idle cycles in the input phase. Without it INPUT waits forever.
//
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   is_game_on     level round enable; low returns to IDLE on the next cycle
//   board_size     tiles per side (2..4), latched on entry to GEN
//   lvl            difficulty (1..3), latched on entry to GEN
//   tile_click     one-cycle click pulse
//   tile_idx       clicked tile, row*board_size + col, valid with tile_click
//   highlight_en   renderer lights tile highlight_idx
//   highlight_idx  tile currently shown (held through the dark gap)
//   input_ready    block is accepting clicks
//   score          correct clicks in the current round
//   game_won       sticky round-won flag
//   game_over      sticky round-lost flag
//   state_dbg      current FSM state (IDLE=0 GEN=1 SHOW=2 GAP=3 INPUT=4
//                  WIN=5 LOSE=6)
//
// Handshake: there is no backpressure. A click is a single-cycle valid pulse
// (tile_click) that is consumed in the cycle it occurs when input_ready is 1
// and dropped otherwise; input_ready acts as the ready indication.
// -----------------------------------------------------------------------------
module game_round_ctl #(
    parameter int unsigned SHOW_UNIT     = 20000000,
    parameter int unsigned GAP_TICKS     = 5000000,
    parameter int unsigned SEQ_MAX       = 8,
    parameter int unsigned INPUT_TIMEOUT = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       is_game_on,
    input  logic [2:0] board_size,
    input  logic [2:0] lvl,
    input  logic       tile_click,
    input  logic [3:0] tile_idx,
    output logic       highlight_en,
    output logic [3:0] highlight_idx,
    output logic       input_ready,
    output logic [7:0] score,
    output logic       game_won,
    output logic       game_over,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_GEN   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4,
        S_WIN   = 3'd5,
        S_LOSE  = 3'd6
    } state_t;

    localparam logic [4:0]  SEQ_MAX_W   = 5'(SEQ_MAX);
    localparam logic [27:0] SHOW_UNIT_W = 28'(SHOW_UNIT);
    // Counters are loaded with duration-1 so a phase lasts exactly "duration"
    // cycles; a zero duration degenerates to a single cycle.
    localparam logic [27:0] GAP_LOAD    = (GAP_TICKS == 0) ? 28'd0 : 28'(GAP_TICKS - 1);

    state_t      state, state_nxt;
    logic [7:0]  lfsr;
    logic        lfsr_fb;
    logic [27:0] tick_cnt;
    logic [27:0] show_ticks;
    logic [27:0] show_load;
    logic [5:0]  n_tiles;
    logic [4:0]  seq_len;
    logic [4:0]  seq_last;
    logic [4:0]  gen_cnt;
    logic [4:0]  ptr, ptr_nxt;
    logic [3:0]  seq [SEQ_MAX];
    logic [3:0]  seq_at_ptr, seq_at_nxt;
    logic        gen_store, click_hit, click_miss;

    logic [5:0]  n_calc;
    logic [4:0]  len_raw, len_calc;
    logic [2:0]  shamt;
    logic [27:0] show_calc;

    logic        highlight_en_d, input_ready_d, game_won_d, game_over_d;
    logic [3:0]  highlight_idx_d;
    logic [7:0]  score_d;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
    assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    // Round parameters derived from the menu inputs, latched on GEN entry.
    assign n_calc    = {3'b000, board_size} * {3'b000, board_size};
    assign len_raw   = {1'b0, lvl, 1'b0} + {2'b00, board_size};
    assign len_calc  = (len_raw > SEQ_MAX_W) ? SEQ_MAX_W : len_raw;
    assign shamt     = (lvl == 3'd0) ? 3'd0 : lvl - 3'd1;
    assign show_calc = SHOW_UNIT_W >> shamt;
    assign show_load = (show_ticks == 28'd0) ? 28'd0 : show_ticks - 28'd1;

    assign seq_last   = seq_len - 5'd1;
    assign gen_store  = {2'b00, lfsr[3:0]} < n_tiles;
    assign click_hit  = tile_click && (tile_idx == seq_at_ptr);
    // Off-board clicks (tile_idx >= N) are neither hits nor misses.
    assign click_miss = tile_click && (tile_idx != seq_at_ptr) &&
                        ({2'b00, tile_idx} < n_tiles);

    assign state_dbg = state;

    // Sequence read ports: current pointer for click checking, next pointer
    // so the registered highlight_idx is ready on the first SHOW cycle.
    always_comb begin
        seq_at_ptr = '0;
        seq_at_nxt = '0;
        for (int i = 0; i < int'(SEQ_MAX); i++) begin
            if (ptr == 5'(i))     seq_at_ptr = seq[i];
            if (ptr_nxt == 5'(i)) seq_at_nxt = seq[i];
        end
    end

`ifdef GAME_ROUND_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST =
        (INPUT_TIMEOUT == 0) ? 32'd0 : 32'(INPUT_TIMEOUT - 1);
    logic [31:0] idle_cnt;

    // Counts INPUT cycles since entry or since the last correct click.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != S_INPUT || click_hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(INPUT_TIMEOUT);
`endif

    // Next-state logic (including the sequence pointer that steers it).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            S_IDLE: begin
                if (is_game_on) begin
                    state_nxt = S_GEN;
                    ptr_nxt   = '0;
                end
            end
            S_GEN: begin
                // L >= 4 for legal inputs, so seq[0] is already stored when
                // the last entry is written and SHOW begins.
                if (gen_store && gen_cnt == seq_last) state_nxt = S_SHOW;
            end
            S_SHOW: begin
                if (tick_cnt == 28'd0) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (tick_cnt == 28'd0) begin
                    if (ptr == seq_last) begin
                        state_nxt = S_INPUT;
                        ptr_nxt   = '0;
                    end else begin
                        state_nxt = S_SHOW;
                        ptr_nxt   = ptr + 5'd1;
                    end
                end
            end
            S_INPUT: begin
                if (click_hit) begin
                    ptr_nxt = ptr + 5'd1;
                    if (ptr == seq_last) state_nxt = S_WIN;
                end else if (click_miss) begin
                    state_nxt = S_LOSE;
                end
`ifdef GAME_ROUND_TIMEOUT_EN
                else if (idle_cnt == TIMEOUT_LAST) begin
                    state_nxt = S_LOSE;
                end
`endif
            end
            S_WIN, S_LOSE: begin
                state_nxt = state;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Menu drop overrides everything, including a same-cycle click.
        if (!is_game_on) begin
            state_nxt = S_IDLE;
            ptr_nxt   = '0;
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        highlight_en_d  = (state_nxt == S_SHOW);
        highlight_idx_d = highlight_idx;
        if (state_nxt == S_SHOW) begin
            highlight_idx_d = seq_at_nxt;
        end else if (state_nxt == S_IDLE) begin
            highlight_idx_d = '0;
        end
        input_ready_d = (state_nxt == S_INPUT);
        score_d       = score;
        if (state_nxt == S_IDLE || state_nxt == S_GEN) begin
            score_d = '0;
        end else if (state == S_INPUT && click_hit && score != 8'hFF) begin
            score_d = score + 8'd1;
        end
        game_won_d  = (state_nxt == S_WIN);
        game_over_d = (state_nxt == S_LOSE);
    end

    // State register and datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            lfsr       <= 8'hA5;
            tick_cnt   <= '0;
            show_ticks <= '0;
            n_tiles    <= '0;
            seq_len    <= '0;
            gen_cnt    <= '0;
            ptr        <= '0;
            for (int i = 0; i < int'(SEQ_MAX); i++) seq[i] <= '0;
        end else begin
            state <= state_nxt;
            lfsr  <= {lfsr[6:0], lfsr_fb};
            ptr   <= ptr_nxt;

            if (state == S_IDLE && state_nxt == S_GEN) begin
                n_tiles    <= n_calc;
                seq_len    <= len_calc;
                show_ticks <= show_calc;
                gen_cnt    <= '0;
            end else if (state == S_GEN && state_nxt != S_IDLE && gen_store) begin
                for (int i = 0; i < int'(SEQ_MAX); i++) begin
                    if (gen_cnt == 5'(i)) seq[i] <= lfsr[3:0];
                end
                gen_cnt <= gen_cnt + 5'd1;
            end

            // One down-counter times both SHOW and GAP; it saturates at 0.
            if (state_nxt == S_SHOW && state != S_SHOW) begin
                tick_cnt <= show_load;
            end else if (state_nxt == S_GAP && state != S_GAP) begin
                tick_cnt <= GAP_LOAD;
            end else if (tick_cnt != 28'd0) begin
                tick_cnt <= tick_cnt - 28'd1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            highlight_en  <= 1'b0;
            highlight_idx <= '0;
            input_ready   <= 1'b0;
            score         <= '0;
            game_won      <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            highlight_en  <= highlight_en_d;
            highlight_idx <= highlight_idx_d;
            input_ready   <= input_ready_d;
            score         <= score_d;
            game_won      <= game_won_d;
            game_over     <= game_over_d;
        end
    end

endmodule

// File: tb/tb_game_round_ctl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctl
//
// Directed bench for game_round_ctl with SHOW_UNIT=8, GAP_TICKS=4, SEQ_MAX=8,
// INPUT_TIMEOUT=50. A reference LFSR runs beside the DUT; the expected tile
// sequence is rebuilt from it during GEN and kept in exp_q. Inputs change and
// outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_round_ctl;

    localparam int SHOW_UNIT = 8;
    localparam int GAP_TICKS = 4;
    localparam int SEQ_MAX   = 8;
    localparam int TIMEOUT   = 50;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GEN   = 3'd1;
    localparam logic [2:0] ST_SHOW  = 3'd2;
    localparam logic [2:0] ST_INPUT = 3'd4;
    localparam logic [2:0] ST_LOSE  = 3'd6;

    logic       clk;
    logic       rst;
    logic       is_game_on;
    logic [2:0] board_size;
    logic [2:0] lvl;
    logic       tile_click;
    logic [3:0] tile_idx;
    logic       highlight_en;
    logic [3:0] highlight_idx;
    logic       input_ready;
    logic [7:0] score;
    logic       game_won;
    logic       game_over;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_lfsr;
    logic [3:0] exp_q[$];
    int         cur_n, cur_l, cur_show;

    game_round_ctl #(
        .SHOW_UNIT     (SHOW_UNIT),
        .GAP_TICKS     (GAP_TICKS),
        .SEQ_MAX       (SEQ_MAX),
        .INPUT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .is_game_on    (is_game_on),
        .board_size    (board_size),
        .lvl           (lvl),
        .tile_click    (tile_click),
        .tile_idx      (tile_idx),
        .highlight_en  (highlight_en),
        .highlight_idx (highlight_idx),
        .input_ready   (input_ready),
        .score         (score),
        .game_won      (game_won),
        .game_over     (game_over),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reference LFSR ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic click(input logic [3:0] idx);
        tile_idx   = idx;
        tile_click = 1'b1;
        tick();
        tile_click = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_outs"}, {highlight_en, highlight_idx, input_ready, score, game_won, game_over}, 32'd0);
        check_eq({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
    endtask

    task automatic end_round(input string tag);
        is_game_on = 1'b0;
        tick();
        check_cleared(tag);
    endtask

    // Raise is_game_on and rebuild the expected sequence from the reference
    // LFSR while the DUT is in GEN; returns on the first SHOW cycle.
    task automatic start_round(input logic [2:0] bs, input logic [2:0] lv);
        int budget;
        cur_n    = int'(bs) * int'(bs);
        cur_l    = 2 * int'(lv) + int'(bs);
        if (cur_l > SEQ_MAX) cur_l = SEQ_MAX;
        cur_show = SHOW_UNIT >> (int'(lv) - 1);
        exp_q.delete();
        board_size = bs;
        lvl        = lv;
        is_game_on = 1'b1;
        tick();
        check_eq("enter_gen", {29'd0, state_dbg}, {29'd0, ST_GEN});
        budget = 0;
        while (exp_q.size() < cur_l && budget < 500) begin
            if (int'(m_lfsr[3:0]) < cur_n) exp_q.push_back(m_lfsr[3:0]);
            tick();
            budget++;
        end
        check_eq("gen_done", exp_q.size(), cur_l);
        check_eq("first_hl", {31'd0, highlight_en}, 32'd1);
    endtask

    // Measure every highlight pulse and gap; returns on the first INPUT cycle.
    task automatic show_all(input bit click_in_show);
        int cnt;
        for (int i = 0; i < cur_l; i++) begin
            check_eq("hl_idx", {28'd0, highlight_idx}, {28'd0, exp_q[i]});
            check_eq("idx_lt_n", {31'd0, (int'(highlight_idx) < cur_n)}, 32'd1);
            cnt = 0;
            while (highlight_en && cnt < 64) begin
                if (click_in_show && i == 0 && cnt == 1) begin
                    tile_idx   = exp_q[0];
                    tile_click = 1'b1;
                end
                tick();
                tile_click = 1'b0;
                cnt++;
            end
            check_eq("show_len", cnt, cur_show);
            check_eq("gap_idx_hold", {28'd0, highlight_idx}, {28'd0, exp_q[i]});
            cnt = 0;
            while (!highlight_en && !input_ready && cnt < 64) begin
                tick();
                cnt++;
            end
            check_eq("gap_len", cnt, GAP_TICKS);
        end
        check_eq("input_ready_up", {31'd0, input_ready}, 32'd1);
        check_eq("score_at_input", {24'd0, score}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int bad;
        int cnt;
        logic [3:0] wrong;

        rst        = 1'b1;
        is_game_on = 1'b0;
        board_size = 3'd0;
        lvl        = 3'd0;
        tile_click = 1'b0;
        tile_idx   = 4'd0;
        repeat (3) tick();
        check_cleared("reset");
        rst = 1'b0;

        // Idle with the menu off for 100 cycles.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({highlight_en, highlight_idx, input_ready, score, game_won, game_over} != '0 ||
                state_dbg != ST_IDLE) bad++;
        end
        check_eq("idle_100", bad, 0);

        // Round A: 2x2, lvl 1 -> L=4, 8-cycle pulses; win by replaying.
        start_round(3'd2, 3'd1);
        show_all(1'b1);
        click(4'd15);
        check_eq("oob_state", {29'd0, state_dbg}, {29'd0, ST_INPUT});
        check_eq("oob_score", {24'd0, score}, 32'd0);
        for (int i = 0; i < cur_l; i++) begin
            click(exp_q[i]);
            check_eq("win_score", {24'd0, score}, i + 1);
        end
        check_eq("won", {31'd0, game_won}, 32'd1);
        check_eq("won_over", {31'd0, game_over}, 32'd0);
        check_eq("won_ready", {31'd0, input_ready}, 32'd0);
        tick();
        check_eq("won_sticky", {31'd0, game_won}, 32'd1);
        end_round("end_a");

        // Round B: 3x3, lvl 3 -> L capped at 8, 2-cycle pulses; lose on 3rd.
        start_round(3'd3, 3'd3);
        show_all(1'b0);
        click(exp_q[0]);
        click(exp_q[1]);
        check_eq("lose_pre_score", {24'd0, score}, 32'd2);
        wrong = (exp_q[2] == 4'd0) ? 4'd1 : 4'd0;
        click(wrong);
        check_eq("lose_over", {31'd0, game_over}, 32'd1);
        check_eq("lose_score", {24'd0, score}, 32'd2);
        check_eq("lose_ready", {31'd0, input_ready}, 32'd0);
        click(exp_q[2]);
        check_eq("lose_frozen", {24'd0, score}, 32'd2);
        check_eq("lose_sticky", {29'd0, state_dbg}, {29'd0, ST_LOSE});
        end_round("end_b");

        // Round C: 2x2, lvl 2; drop the menu in the first gap.
        start_round(3'd2, 3'd2);
        cnt = 0;
        while (highlight_en && cnt < 64) begin
            tick();
            cnt++;
        end
        check_eq("c_show_len", cnt, 4);
        end_round("abort_gap");

        // Round E: reset in the middle of SHOW.
        start_round(3'd3, 3'd1);
        tick();
        tick();
        check_eq("pre_rst_state", {29'd0, state_dbg}, {29'd0, ST_SHOW});
        rst = 1'b1;
        tick();
        check_cleared("mid_rst");
        rst        = 1'b0;
        is_game_on = 1'b0;
        tick();

        // Round F: menu drop in the same cycle as a correct click.
        start_round(3'd2, 3'd1);
        show_all(1'b0);
        is_game_on = 1'b0;
        click(exp_q[0]);
        check_cleared("drop_vs_click");

        // Round D: no clicks in INPUT.
        start_round(3'd2, 3'd1);
        show_all(1'b0);
`ifdef GAME_ROUND_TIMEOUT_EN
        cnt = 0;
        while (!game_over && cnt < 200) begin
            tick();
            cnt++;
        end
        check_eq("timeout_cycles", cnt, TIMEOUT);
        check_eq("timeout_ready", {31'd0, input_ready}, 32'd0);
`else
        repeat (1000) tick();
        check_eq("no_timeout_state", {29'd0, state_dbg}, {29'd0, ST_INPUT});
        check_eq("no_timeout_ready", {31'd0, input_ready}, 32'd1);
`endif
        end_round("end_d");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
